crossbar_cfg_ctrl: RTL and testbench
====================================

CROSSBAR_CFG_CTRL -- requirements
Module: crossbar_cfg_ctrl

Upstream control stage for the N x N registered-switch crossbar: accepts permutation configurations, validates them, drives the switch-array ctrl vector, gates source data during reconfiguration drain, and generates per-output valid aligned to crossbar path latency.

Interface
REQ-001 Parameter N, default 8: crossbar port count; W = ceil(log2(N)), minimum 1, is a derived localparam.
REQ-002 clk  input  1  the only clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 cfg_valid  input  1  configuration request valid.
REQ-005 cfg_ready  output  1  configuration can be accepted this cycle.
REQ-006 cfg_dst  input  N*W  destination output for input lane i in bits [i*W +: W].
REQ-007 cfg_en  input  N  lane i enabled when cfg_en[i]=1.
REQ-008 cfg_err  output  1  one-cycle pulse: the accepted configuration was illegal and was discarded.
REQ-009 dat_valid  input  1  source presents one N-lane data beat on the crossbar input.
REQ-010 dat_ready  output  1  beat accepted when dat_valid && dat_ready.
REQ-011 ctrl  output  N*N  registered switch-control vector; bit i*N+j controls the switch at row i, column j.
REQ-012 out_valid  output  N  out_valid[j]=1 when crossbar output lane j carries valid data this cycle.

Function
REQ-013 The FSM SHALL have three states: IDLE (no configuration loaded), RUN, and DRAIN.
REQ-014 cfg_ready SHALL be 1 in IDLE and RUN and 0 in DRAIN; dat_ready SHALL be 1 only in RUN.
REQ-015 A configuration is accepted on a cycle with cfg_valid && cfg_ready.
REQ-016 A configuration is illegal if any enabled lane has cfg_dst >= N, or if two enabled lanes have equal cfg_dst; disabled lanes are ignored.
REQ-017 Illegal accept: cfg_err=1 for the next cycle only; state, ctrl and pending configuration remain unchanged.
REQ-018 Legal target SHALL be ctrl bit i*N+j = cfg_en[i] && (cfg_dst[i]==j), with every other bit 0.
REQ-019 Legal accept in IDLE: ctrl SHALL load the target at the same clock edge; the next state is RUN.
REQ-020 Legal accept in RUN: the target is latched as pending; ctrl is held; the next state is DRAIN with a drain counter of 2N-1.
REQ-021 DRAIN decrements the counter each cycle.
REQ-022 On the cycle the counter equals 1, ctrl loads pending at the edge, and the next state is RUN; DRAIN therefore lasts exactly 2N-1 cycles.
REQ-023 A beat accepted in the same cycle as a legal RUN config accept SHALL travel under the old ctrl.
REQ-024 Path latency for lane i routed to output j SHALL be L(i,j) = N + j - i cycles (range 1 to 2N-1).
REQ-025 out_valid[j] SHALL be 1 exactly L(i,j) cycles after the acceptance cycle of a beat, where i is the enabled lane whose ctrl bit i*N+j is set; otherwise 0.
REQ-026 out_valid SHALL be computed from the currently applied ctrl and a per-lane accept history of depth 2N-1, and SHALL be registered.
REQ-027 An all-disabled configuration is legal: ctrl=0, and out_valid stays 0.
REQ-028 No beat may be accepted while ctrl could change before its last switch traversal; this is guaranteed by REQ-014 and REQ-022.

Reset
REQ-029 While rst=0: state=IDLE, ctrl=0, out_valid=0, cfg_err=0, drain counter=0, pending=0, accept history=0.
REQ-030 After reset, cfg_ready=1 and dat_ready=0.
REQ-031 Reset asserted mid-DRAIN SHALL discard the pending configuration and all in-flight valid tracking.

Verification (N=4)
REQ-032 Reset, then identity config (dst=0,1,2,3, en=4'hF) -> next cycle ctrl=16'h8421, RUN; one beat accepted -> out_valid=4'hF exactly 4 cycles later, for one cycle.
REQ-033 Reversal config (dst=3,2,1,0) from IDLE -> ctrl=16'h1248; one beat -> out_valid[0] at +1, [1] at +3, [2] at +5, [3] at +7 cycles.
REQ-034 In RUN with continuous dat_valid, new legal config -> dat_ready low for exactly 7 cycles, ctrl unchanged for those 7 cycles, then updated; out_valid pattern of the last old beat is still correct.
REQ-035 dst=1,1,2,3 with en=4'hF -> cfg_err pulses 1 cycle, ctrl unchanged; the same dst with en=4'hE -> legal, ctrl=16'h8420.
REQ-036 Assert rst in DRAIN cycle 3 -> all outputs reset immediately; after release, state is IDLE, ctrl=0, and no out_valid occurs.
REQ-037 Continuous dat_valid under identity plus random cfg_valid -> a scoreboard confirms out_valid never asserts for unaccepted beats and never misses an accepted one.

Source files
------------

// File: rtl/crossbar_cfg_ctrl_if.sv
// Bus bundle for the crossbar configuration/control stage.
//   master : configuration source and data source (drives cfg_valid, cfg_dst,
//            cfg_en, dat_valid; observes readiness, error, ctrl, out_valid)
//   slave  : crossbar_cfg_ctrl (drives cfg_ready, cfg_err, dat_ready, ctrl,
//            out_valid)
// cfg_dst packs one W-bit destination per input lane at [i*W +: W];
// ctrl bit i*N+j closes the switch at row i, column j.
interface crossbar_cfg_ctrl_if #(
    parameter int N = 8
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic           cfg_valid;
    logic           cfg_ready;
    logic [N*W-1:0] cfg_dst;
    logic [N-1:0]   cfg_en;
    logic           cfg_err;
    logic           dat_valid;
    logic           dat_ready;
    logic [N*N-1:0] ctrl;
    logic [N-1:0]   out_valid;

    modport master (
        output cfg_valid, cfg_dst, cfg_en, dat_valid,
        input  cfg_ready, cfg_err, dat_ready, ctrl, out_valid
    );

    modport slave (
        input  cfg_valid, cfg_dst, cfg_en, dat_valid,
        output cfg_ready, cfg_err, dat_ready, ctrl, out_valid
    );
endinterface

// File: rtl/crossbar_cfg_ctrl.sv
// Control stage for an N x N registered-switch crossbar.
// Accepts permutation configurations, rejects illegal ones with a one-cycle
// cfg_err pulse, drives the switch-control vector, stalls the data source
// while the array drains before a reconfiguration, and produces per-output
// valid flags aligned to the path latency N + j - i of lane i -> output j.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : crossbar_cfg_ctrl_if slave modport (config, data handshake,
//         ctrl vector, out_valid)
module crossbar_cfg_ctrl #(
    parameter int N = 8
) (
    input logic                clk,
    input logic                rst,
    crossbar_cfg_ctrl_if.slave bus
);
    localparam int W  = (N > 1) ? $clog2(N) : 1;
    localparam int D  = 2 * N - 1;
    localparam int CW = $clog2(D + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [N*N-1:0] ctrl_q, ctrl_next;
    logic [N*N-1:0] pend, pend_next;
    logic [N*N-1:0] target;
    logic           illegal;
    logic           lane_hit;
    logic           err_q, err_next;
    logic           cfg_ready, dat_ready;
    logic           cfg_acc, dat_acc;
    logic [D-1:0]   hist;
    logic [N-1:0]   ov_q, ov_next;

    // Decode the requested permutation and check it. A lane whose destination
    // matches no output column is out of range; any two enabled lanes sharing a
    // destination is a conflict.
    always_comb begin
        target   = '0;
        illegal  = 1'b0;
        lane_hit = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.cfg_en[i]) begin
                lane_hit = 1'b0;
                for (int unsigned j = 0; j < N; j++) begin
                    if (bus.cfg_dst[i*W +: W] == W'(j)) begin
                        target[i*N + j] = 1'b1;
                        lane_hit        = 1'b1;
                    end
                end
                if (!lane_hit) begin
                    illegal = 1'b1;
                end
                for (int unsigned k = i + 1; k < N; k++) begin
                    if (bus.cfg_en[k] && (bus.cfg_dst[k*W +: W] == bus.cfg_dst[i*W +: W])) begin
                        illegal = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        cfg_ready  = (state != DRAIN);
        dat_ready  = (state == RUN);
        cfg_acc    = bus.cfg_valid && cfg_ready;
        dat_acc    = bus.dat_valid && dat_ready;
        state_next = state;
        cnt_next   = cnt;
        ctrl_next  = ctrl_q;
        pend_next  = pend;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_acc) begin
                    if (illegal) begin
                        err_next = 1'b1;
                    end else begin
                        ctrl_next  = target;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (cfg_acc) begin
                    if (illegal) begin
                        err_next = 1'b1;
                    end else begin
                        pend_next  = target;
                        cnt_next   = CW'(D);
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                cnt_next = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    ctrl_next  = pend;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // out_valid[j] fires L = N + j - i cycles after a beat entered on lane i.
    // Since the flag is registered, the tap needed one edge earlier is
    // "accepted L-1 cycles ago": the live accept for L = 1, hist[L-2] otherwise.
    always_comb begin
        ov_next = '0;
        for (int unsigned j = 0; j < N; j++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (ctrl_q[i*N + j]) begin
                    if (N + j - i == 1) begin
                        ov_next[j] = ov_next[j] | dat_acc;
                    end else begin
                        ov_next[j] = ov_next[j] | hist[(N + j - i >= 2) ? (N + j - i - 2) : 0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            ctrl_q <= '0;
            pend   <= '0;
            err_q  <= 1'b0;
            hist   <= '0;
            ov_q   <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            ctrl_q <= ctrl_next;
            pend   <= pend_next;
            err_q  <= err_next;
            hist   <= (hist << 1) | D'(dat_acc);
            ov_q   <= ov_next;
        end
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.dat_ready = dat_ready;
    assign bus.cfg_err   = err_q;
    assign bus.ctrl      = ctrl_q;
    assign bus.out_valid = ov_q;
endmodule

// File: tb/tb_crossbar_cfg_ctrl.sv
// Self-checking bench for crossbar_cfg_ctrl at N=4: directed scenarios with
// literal expectations plus a randomized run, all cross-checked every cycle
// against a route-table / event-schedule model of the control stage.
module tb_crossbar_cfg_ctrl;
    localparam int N = 4;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;

    crossbar_cfg_ctrl_if #(.N(N)) bus ();

    crossbar_cfg_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: route[i] is the output lane i feeds (-1 = off),
    // drain_left counts remaining stall cycles, sched maps cycle -> out_valid.
    int           route      [N];
    int           pend_route [N];
    int           new_route  [N];
    bit           loaded;
    int           drain_left;
    logic         m_err;
    bit           m_cready;
    bit           m_dready;
    int           cyc = 0;
    logic [N-1:0] sched [int];
    logic [N-1:0] exp_ov;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N*N-1:0] route_vec();
        logic [N*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (route[i] >= 0) v[i*N + route[i]] = 1'b1;
        end
        return v;
    endfunction

    function automatic bit legal_cfg(input logic [N*W-1:0] dst, input logic [N-1:0] en);
        bit used [N];
        int d;
        for (int i = 0; i < N; i++) used[i] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                d = int'(dst[i*W +: W]);
                if (d >= N) return 1'b0;
                if (used[d]) return 1'b0;
                used[d] = 1'b1;
            end
        end
        return 1'b1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            route[i]      = -1;
            pend_route[i] = -1;
        end
        loaded     = 1'b0;
        drain_left = 0;
        m_err      = 1'b0;
        sched.delete();
    endtask

    task automatic sched_add(input int at, input int lane);
        logic [N-1:0] b;
        b = '0;
        b[lane] = 1'b1;
        if (sched.exists(at)) sched[at] = sched[at] | b;
        else sched[at] = b;
    endtask

    // Compare process: model vs DUT every cycle, then advance the model.
    always @(negedge clk) begin
        if (!rst) begin
            m_reset();
            check("rst_ctrl", 64'(bus.ctrl), 64'h0);
            check("rst_out_valid", 64'(bus.out_valid), 64'h0);
            check("rst_cfg_err", 64'(bus.cfg_err), 64'h0);
            check("rst_cfg_ready", 64'(bus.cfg_ready), 64'h1);
            check("rst_dat_ready", 64'(bus.dat_ready), 64'h0);
        end else begin
            exp_ov = '0;
            if (sched.exists(cyc)) begin
                exp_ov = sched[cyc];
                sched.delete(cyc);
            end
            m_cready = (drain_left == 0);
            m_dready = loaded && (drain_left == 0);
            check("cfg_ready", 64'(bus.cfg_ready), 64'(m_cready));
            check("dat_ready", 64'(bus.dat_ready), 64'(m_dready));
            check("ctrl", 64'(bus.ctrl), 64'(route_vec()));
            check("cfg_err", 64'(bus.cfg_err), 64'(m_err));
            check("out_valid", 64'(bus.out_valid), 64'(exp_ov));

            m_err = 1'b0;
            if (bus.dat_valid && m_dready) begin
                for (int i = 0; i < N; i++) begin
                    if (route[i] >= 0) sched_add(cyc + N + route[i] - i, route[i]);
                end
            end
            if (drain_left > 0) begin
                drain_left--;
                if (drain_left == 0) route = pend_route;
            end else if (bus.cfg_valid && m_cready) begin
                if (!legal_cfg(bus.cfg_dst, bus.cfg_en)) begin
                    m_err = 1'b1;
                end else begin
                    for (int i = 0; i < N; i++)
                        new_route[i] = bus.cfg_en[i] ? int'(bus.cfg_dst[i*W +: W]) : -1;
                    if (!loaded) begin
                        route  = new_route;
                        loaded = 1'b1;
                    end else begin
                        pend_route = new_route;
                        drain_left = 2 * N - 1;
                    end
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) tick();
        rst = 1'b1;
    endtask

    task automatic send_cfg(input logic [N*W-1:0] dst, input logic [N-1:0] en);
        bus.cfg_dst   = dst;
        bus.cfg_en    = en;
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] e;
        int r;
        bus.cfg_valid = 1'b0;
        bus.cfg_dst   = '0;
        bus.cfg_en    = '0;
        bus.dat_valid = 1'b0;

        // Reset, identity configuration, single beat
        do_reset(3);
        tick();
        send_cfg(8'hE4, 4'hF);
        bus.dat_valid = 1'b1;
        check("model_ident_ctrl", 64'(route_vec()), 64'h8421);
        @(negedge clk);
        check("ident_ctrl", 64'(bus.ctrl), 64'h8421);
        check("ident_dat_ready", 64'(bus.dat_ready), 64'h1);
        tick();
        bus.dat_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("ident_out_valid", 64'(bus.out_valid), (k == 4) ? 64'hF : 64'h0);
            tick();
        end

        // Reversal from IDLE, single beat
        do_reset(1);
        send_cfg(8'h1B, 4'hF);
        bus.dat_valid = 1'b1;
        check("model_rev_ctrl", 64'(route_vec()), 64'h1248);
        @(negedge clk);
        check("rev_ctrl", 64'(bus.ctrl), 64'h1248);
        tick();
        bus.dat_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            case (k)
                1:       e = 4'h1;
                3:       e = 4'h2;
                5:       e = 4'h4;
                7:       e = 4'h8;
                default: e = 4'h0;
            endcase
            @(negedge clk);
            check("rev_out_valid", 64'(bus.out_valid), 64'(e));
            tick();
        end

        // Reconfiguration under continuous data
        bus.dat_valid = 1'b1;
        repeat (3) tick();
        send_cfg(8'hE4, 4'hF);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("drain_dat_ready", 64'(bus.dat_ready), 64'h0);
            check("drain_ctrl_held", 64'(bus.ctrl), 64'h1248);
            if (k == 7) check("drain_last_old_beat", 64'(bus.out_valid), 64'h8);
            tick();
        end
        @(negedge clk);
        check("post_drain_dat_ready", 64'(bus.dat_ready), 64'h1);
        check("post_drain_ctrl", 64'(bus.ctrl), 64'h8421);
        check("post_drain_out_valid", 64'(bus.out_valid), 64'h0);
        tick();
        bus.dat_valid = 1'b0;
        repeat (6) tick();

        // Illegal duplicate destination, then the same with lane 0 disabled
        send_cfg(8'hE5, 4'hF);
        @(negedge clk);
        check("illegal_err_pulse", 64'(bus.cfg_err), 64'h1);
        check("illegal_ctrl_held", 64'(bus.ctrl), 64'h8421);
        tick();
        @(negedge clk);
        check("illegal_err_end", 64'(bus.cfg_err), 64'h0);
        tick();
        send_cfg(8'hE5, 4'hE);
        repeat (7) tick();
        check("model_masked_ctrl", 64'(route_vec()), 64'h8420);
        @(negedge clk);
        check("masked_ctrl", 64'(bus.ctrl), 64'h8420);
        check("masked_no_err", 64'(bus.cfg_err), 64'h0);
        tick();

        // Reset asserted in the third drain cycle
        bus.dat_valid = 1'b1;
        repeat (2) tick();
        send_cfg(8'hE4, 4'hF);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("midrst_ctrl", 64'(bus.ctrl), 64'h0);
        check("midrst_out_valid", 64'(bus.out_valid), 64'h0);
        check("midrst_cfg_ready", 64'(bus.cfg_ready), 64'h1);
        check("midrst_dat_ready", 64'(bus.dat_ready), 64'h0);
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("after_rst_ctrl", 64'(bus.ctrl), 64'h0);
            check("after_rst_out_valid", 64'(bus.out_valid), 64'h0);
            check("after_rst_idle", 64'(bus.dat_ready), 64'h0);
            tick();
        end

        // All lanes disabled: legal, empty ctrl, no output valid
        send_cfg(8'($urandom()), 4'h0);
        check("model_empty_ctrl", 64'(route_vec()), 64'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("empty_ctrl", 64'(bus.ctrl), 64'h0);
            check("empty_dat_ready", 64'(bus.dat_ready), 64'h1);
            check("empty_out_valid", 64'(bus.out_valid), 64'h0);
            tick();
        end
        bus.dat_valid = 1'b0;

        // Randomized run against the model
        do_reset(2);
        send_cfg(8'hE4, 4'hF);
        for (int n = 0; n < 800; n++) begin
            bus.dat_valid = (n < 400) ? 1'b1 : 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                bus.cfg_dst   = 8'hE4;
                bus.cfg_en    = 4'hF;
                bus.cfg_valid = 1'b1;
            end else if (r < 14) begin
                bus.cfg_dst   = 8'($urandom());
                bus.cfg_en    = 4'($urandom());
                bus.cfg_valid = 1'b1;
            end else begin
                bus.cfg_valid = 1'b0;
            end
            tick();
        end
        bus.dat_valid = 1'b0;
        bus.cfg_valid = 1'b0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
